// File: rtl/cam_video_pkg.sv
// Shared video constants and mode encodings for the 320x240
// 3x3 filter stage running on an 800x525 raster.
package cam_video_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GAUSS  = 2'd1;
  localparam logic [1:0] MODE_SOBEL  = 2'd2;

  localparam int VID_IMG_W        = 320;
  localparam int VID_IMG_H        = 240;
  localparam int VID_H_TOTAL      = 800;
  localparam int VID_V_TOTAL      = 525;
  localparam int VID_V_SYNC_START = 490;
  localparam int VID_V_SYNC_LEN   = 2;
  localparam int VID_FILTER_LAT   = 3;
  localparam int VID_EXP_READY    = VID_IMG_W * VID_IMG_H - 3;

  localparam int HCW = 10;
  localparam int VCW = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } seq_state_e;

  // Reserved encoding 3 is stored as bypass.
  function automatic logic [1:0] mode_sanitize(input logic [1:0] m);
    return (m == 2'd3) ? MODE_BYPASS : m;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register pipeline with synchronous clear,
// used to align the output-mux select with filter latency.
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  // Shift by one stage per clock, or flush every stage on clr.
  always_comb begin
    pipe_d[0] = clr ? '0 : din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = clr ? '0 : pipe_q[i-1];
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/filter_frame_sequencer.sv
// Frame-level raster sequencer for the 3x3 filter stage: scan
// counters, frame-boundary mode switching and ready checking.
module filter_frame_sequencer
  import cam_video_pkg::*;
#(
  parameter int IMG_W        = VID_IMG_W,
  parameter int IMG_H        = VID_IMG_H,
  parameter int H_TOTAL      = VID_H_TOTAL,
  parameter int V_TOTAL      = VID_V_TOTAL,
  parameter int V_SYNC_START = VID_V_SYNC_START,
  parameter int V_SYNC_LEN   = VID_V_SYNC_LEN,
  parameter int FILTER_LAT   = VID_FILTER_LAT,
  parameter int EXP_READY    = VID_EXP_READY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [1:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  input  logic        filter_ready,
  output logic [16:0] pixel_addr,
  output logic        active_area,
  output logic        vsync,
  output logic        gauss_enable,
  output logic        sobel_enable,
  output logic [1:0]  out_sel,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        ready_err
);

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] W_LIM  = HCW'(IMG_W);
  localparam logic [VCW-1:0] H_LIM  = VCW'(IMG_H);
  localparam logic [VCW-1:0] VS_LO  = VCW'(V_SYNC_START);
  localparam logic [VCW-1:0] VS_HI  = VCW'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [16:0]    EXP_C  = 17'(EXP_READY);

  seq_state_e state_q, state_d;

  logic [HCW-1:0] h_q, h_d;
  logic [VCW-1:0] v_q, v_d;
  logic           is_end, is_first, scan_d;

  logic [1:0]  cur_mode_q, cur_mode_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  logic        pend_q, pend_d;
  logic        accept, apply;
  logic [16:0] rcnt_q, rcnt_d, rsum;
  logic [15:0] frame_count_q, frame_count_d;
  logic        ready_err_q, ready_err_d;

  logic [16:0] pixel_addr_q, pixel_addr_d;
  logic        active_q, active_d;
  logic        vsync_q, vsync_d;
  logic        gauss_q, gauss_d;
  logic        sobel_q, sobel_d;
  logic        fs_q, fs_d;
  logic        fd_q, fd_d;
  logic        mrr_q, mrr_d;

  assign is_end   = (state_q == ST_SCAN) && (h_q == H_LAST) &&
                    (v_q == V_LAST);
  assign is_first = (state_q == ST_SCAN) && (h_q == '0) &&
                    (v_q == '0);
  assign scan_d   = (state_d == ST_SCAN);
  assign accept   = mode_req_valid && !pend_q;
  assign apply    = pend_q && (is_end || (state_q == ST_IDLE));
  assign rsum     = rcnt_q + {16'b0, filter_ready};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: start on run, stop only at a frame end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_SCAN;
      ST_SCAN: if (is_end && !run) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster position of the cycle being entered.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if ((state_q == ST_SCAN) && !is_end) begin
      if (h_q == H_LAST) begin
        v_d = v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  // Mode handshake, frame counter and ready-pulse checker.
  always_comb begin
    cur_mode_d    = cur_mode_q;
    pend_d        = pend_q;
    pend_mode_d   = pend_mode_q;
    rcnt_d        = rcnt_q;
    frame_count_d = frame_count_q + 16'(is_end);
    ready_err_d   = ready_err_q;
    if (apply) begin
      cur_mode_d = pend_mode_q;
      pend_d     = 1'b0;
    end
    if (accept) begin
      pend_d      = 1'b1;
      pend_mode_d = mode_sanitize(mode_req);
    end
    if (is_first) begin
      rcnt_d = {16'b0, filter_ready};
    end else if (state_q == ST_SCAN) begin
      rcnt_d = rsum;
    end
    if (is_end && (cur_mode_q != MODE_BYPASS) && (rsum != EXP_C)) begin
      ready_err_d = 1'b1;
    end
  end

  // Registered outputs, all computed for the cycle being entered.
  always_comb begin
    active_d = scan_d && (h_d < W_LIM) && (v_d < H_LIM);
    if (!scan_d)       pixel_addr_d = '0;
    else if (active_d) pixel_addr_d = {v_d[7:0], h_d[8:0]};
    else               pixel_addr_d = pixel_addr_q;
    vsync_d = scan_d && (v_d >= VS_LO) && (v_d < VS_HI);
    gauss_d = scan_d && (cur_mode_d == MODE_GAUSS);
    sobel_d = scan_d && (cur_mode_d == MODE_SOBEL);
    fs_d    = scan_d && (h_d == '0) && (v_d == '0);
    fd_d    = scan_d && (h_d == H_LAST) && (v_d == V_LAST);
    mrr_d   = !pend_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      cur_mode_q    <= MODE_BYPASS;
      pend_q        <= 1'b0;
      pend_mode_q   <= MODE_BYPASS;
      rcnt_q        <= '0;
      frame_count_q <= '0;
      ready_err_q   <= 1'b0;
      pixel_addr_q  <= '0;
      active_q      <= 1'b0;
      vsync_q       <= 1'b0;
      gauss_q       <= 1'b0;
      sobel_q       <= 1'b0;
      fs_q          <= 1'b0;
      fd_q          <= 1'b0;
      mrr_q         <= 1'b1;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      cur_mode_q    <= cur_mode_d;
      pend_q        <= pend_d;
      pend_mode_q   <= pend_mode_d;
      rcnt_q        <= rcnt_d;
      frame_count_q <= frame_count_d;
      ready_err_q   <= ready_err_d;
      pixel_addr_q  <= pixel_addr_d;
      active_q      <= active_d;
      vsync_q       <= vsync_d;
      gauss_q       <= gauss_d;
      sobel_q       <= sobel_d;
      fs_q          <= fs_d;
      fd_q          <= fd_d;
      mrr_q         <= mrr_d;
    end
  end

  // Enables encode the live mode as {sobel, gauss}.
  sync_delay_line #(
    .WIDTH (2),
    .DEPTH (FILTER_LAT)
  ) u_sel_dly (
    .clk  (clk),
    .rst  (rst),
    .clr  (!scan_d),
    .din  ({sobel_q, gauss_q}),
    .dout (out_sel)
  );

  assign mode_req_ready = mrr_q;
  assign pixel_addr     = pixel_addr_q;
  assign active_area    = active_q;
  assign vsync          = vsync_q;
  assign gauss_enable   = gauss_q;
  assign sobel_enable   = sobel_q;
  assign frame_start    = fs_q;
  assign frame_done     = fd_q;
  assign frame_count    = frame_count_q;
  assign ready_err      = ready_err_q;

endmodule
